// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file.
//   DEFAULT_WIDTH / DEFAULT_DEPTH : default data width and register count
//   win_t / win_port()            : resolves which write port owns an address
package regfile_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;
  localparam int unsigned DEFAULT_DEPTH = 32;

  // win_port() works on fixed-size padded vectors so it can serve any NW/AW
  // up to these limits; callers zero-extend their buses into this shape.
  localparam int unsigned MAX_NW    = 16;
  localparam int unsigned MAX_AW    = 16;
  localparam int unsigned WIN_IDX_W = $clog2(MAX_NW);

  typedef struct packed {
    logic                 valid;
    logic [WIN_IDX_W-1:0] idx;
  } win_t;

  // Highest-indexed enabled port whose address matches wins.
  function automatic win_t win_port(input logic [MAX_NW-1:0]        we,
                                    input logic [MAX_NW*MAX_AW-1:0] wn,
                                    input logic [MAX_AW-1:0]        addr);
    win_t win;
    win = '0;
    for (int unsigned w = 0; w < MAX_NW; w++) begin
      if (we[w] && (wn[w*MAX_AW +: MAX_AW] == addr)) begin
        win.valid = 1'b1;
        win.idx   = w[WIN_IDX_W-1:0];
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Bus bundle for regfile_mp.
//   rn/q/q_rdy          : NR read ports (address, data, data-ready)
//   we/wn/d/wclr        : NW write ports (enable, address, data, clear-pending)
//   mark/mark_n         : set the pending bit of one register
//   pend                : pending-bit vector
// master = pipeline side, slave = register file.
interface regfile_mp_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 32,
  parameter int unsigned NR    = 2,
  parameter int unsigned NW    = 2
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [NR*AW-1:0]    rn;
  logic [NR*WIDTH-1:0] q;
  logic [NR-1:0]       q_rdy;
  logic [NW-1:0]       we;
  logic [NW*AW-1:0]    wn;
  logic [NW*WIDTH-1:0] d;
  logic [NW-1:0]       wclr;
  logic                mark;
  logic [AW-1:0]       mark_n;
  logic [DEPTH-1:0]    pend;

  modport master (
    output rn, we, wn, d, wclr, mark, mark_n,
    input  q, q_rdy, pend
  );

  modport slave (
    input  rn, we, wn, d, wclr, mark, mark_n,
    output q, q_rdy, pend
  );

endinterface

// File: rtl/regfile_bypass.sv
// One read port: write-to-read bypass, zero-register mux and ready flag.
//   rn       : read address
//   we/wclr  : write enables / clear-pending flags of all write ports
//   wn/d     : write addresses / data of all write ports
//   rdata    : array contents at rn
//   pend_bit : pending bit of rn
//   q/q_rdy  : read data and data-valid
module regfile_bypass import regfile_pkg::*; #(
  parameter int unsigned WIDTH    = DEFAULT_WIDTH,
  parameter int unsigned AW       = 5,
  parameter int unsigned NW       = 2,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic [AW-1:0]       rn,
  input  logic [NW-1:0]       we,
  input  logic [NW-1:0]       wclr,
  input  logic [NW*AW-1:0]    wn,
  input  logic [NW*WIDTH-1:0] d,
  input  logic [WIDTH-1:0]    rdata,
  input  logic                pend_bit,
  output logic [WIDTH-1:0]    q,
  output logic                q_rdy
);

  logic [MAX_NW-1:0]        we_pad;
  logic [MAX_NW*MAX_AW-1:0] wn_pad;
  logic [MAX_AW-1:0]        rn_pad;
  win_t                     win;
  logic                     clr_hit;

  always_comb begin
    we_pad = '0;
    wn_pad = '0;
    rn_pad = '0;
    we_pad[NW-1:0] = we;
    rn_pad[AW-1:0] = rn;
    for (int unsigned w = 0; w < NW; w++) begin
      wn_pad[w*MAX_AW +: AW] = wn[w*AW +: AW];
    end
    win = win_port(we_pad, wn_pad, rn_pad);

    // Any clearing write to rn makes it ready, regardless of which port wins the data.
    clr_hit = 1'b0;
    for (int unsigned w = 0; w < NW; w++) begin
      if (we[w] && wclr[w] && (wn[w*AW +: AW] == rn)) clr_hit = 1'b1;
    end

    q = rdata;
    for (int unsigned w = 0; w < NW; w++) begin
      if (win.valid && (win.idx == w[WIN_IDX_W-1:0])) q = d[w*WIDTH +: WIDTH];
    end
    q_rdy = ~pend_bit | clr_hit;

    if (ZERO_REG && (rn == '0)) begin
      q     = '0;
      q_rdy = 1'b1;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with write bypass and pending-write scoreboard.
//   clk  : clock, all state updates on the rising edge
//   rst  : synchronous active-high reset (clears registers and pending bits)
//   bus  : regfile_mp_if slave (read ports, write ports, mark, pend)
module regfile_mp import regfile_pkg::*; #(
  parameter int unsigned WIDTH    = DEFAULT_WIDTH,
  parameter int unsigned DEPTH    = DEFAULT_DEPTH,
  parameter int unsigned AW       = $clog2(DEPTH),
  parameter int unsigned NR       = 2,
  parameter int unsigned NW       = 2,
  parameter bit          ZERO_REG = 1'b1
) (
  input logic         clk,
  input logic         rst,
  regfile_mp_if.slave bus
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0] pend_q, pend_d;

  // Clears first, then the mark, so a new producer beats a retiring one.
  always_comb begin
    pend_d = pend_q;
    for (int unsigned w = 0; w < NW; w++) begin
      if (bus.we[w] && bus.wclr[w]) pend_d[bus.wn[w*AW +: AW]] = 1'b0;
    end
    if (bus.mark) pend_d[bus.mark_n] = 1'b1;
    if (ZERO_REG) pend_d[0] = 1'b0;
  end

  // Later loop iterations override earlier ones: highest write port wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      pend_q <= pend_d;
      for (int unsigned w = 0; w < NW; w++) begin
        if (bus.we[w] && !(ZERO_REG && (bus.wn[w*AW +: AW] == '0))) begin
          mem_q[bus.wn[w*AW +: AW]] <= bus.d[w*WIDTH +: WIDTH];
        end
      end
    end
  end

  assign bus.pend = pend_q;

  for (genvar r = 0; r < NR; r++) begin : g_rd
    logic [AW-1:0]    rn_r;
    logic [WIDTH-1:0] q_r;
    logic             rdy_r;

    assign rn_r = bus.rn[r*AW +: AW];

    regfile_bypass #(
      .WIDTH    (WIDTH),
      .AW       (AW),
      .NW       (NW),
      .ZERO_REG (ZERO_REG)
    ) u_bypass (
      .rn       (rn_r),
      .we       (bus.we),
      .wclr     (bus.wclr),
      .wn       (bus.wn),
      .d        (bus.d),
      .rdata    (mem_q[rn_r]),
      .pend_bit (pend_q[rn_r]),
      .q        (q_r),
      .q_rdy    (rdy_r)
    );

    assign bus.q[r*WIDTH +: WIDTH] = q_r;
    assign bus.q_rdy[r]            = rdy_r;
  end

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned DEPTH = 32;
  localparam int unsigned NR    = 2;
  localparam int unsigned NW    = 2;

  logic clk;
  logic rst;

  regfile_mp_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NR(NR), .NW(NW)) bus ();

  regfile_mp #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .NR       (NR),
    .NW       (NW),
    .ZERO_REG (1'b1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  typedef struct {
    logic        rst;
    logic [1:0]  we;
    logic [4:0]  wn0, wn1;
    logic [31:0] d0, d1;
    logic [1:0]  wclr;
    logic        mark;
    logic [4:0]  mark_n;
    logic [4:0]  rn0, rn1;
    logic [31:0] eq0, eq1;
    logic [1:0]  erdy;
    logic [31:0] epend;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic r, input logic [1:0] we, input logic [4:0] wn0,
                         input logic [4:0] wn1, input logic [31:0] d0, input logic [31:0] d1,
                         input logic [1:0] wclr, input logic mark, input logic [4:0] mark_n,
                         input logic [4:0] rn0, input logic [4:0] rn1, input logic [31:0] eq0,
                         input logic [31:0] eq1, input logic [1:0] erdy,
                         input logic [31:0] epend);
    vec_t v;
    v.rst = r; v.we = we; v.wn0 = wn0; v.wn1 = wn1; v.d0 = d0; v.d1 = d1;
    v.wclr = wclr; v.mark = mark; v.mark_n = mark_n; v.rn0 = rn0; v.rn1 = rn1;
    v.eq0 = eq0; v.eq1 = eq1; v.erdy = erdy; v.epend = epend;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic r, input logic [1:0] we, input logic [4:0] wn0,
                       input logic [4:0] wn1, input logic [31:0] d0, input logic [31:0] d1,
                       input logic [1:0] wclr, input logic mark, input logic [4:0] mark_n,
                       input logic [4:0] rn0, input logic [4:0] rn1);
    rst        = r;
    bus.we     = we;
    bus.wn     = {wn1, wn0};
    bus.d      = {d1, d0};
    bus.wclr   = wclr;
    bus.mark   = mark;
    bus.mark_n = mark_n;
    bus.rn     = {rn1, rn0};
  endtask

  // Behavioural reference: register values and pending flags as plain arrays.
  logic [31:0] m_reg  [DEPTH];
  bit          m_pend [DEPTH];

  function automatic logic [31:0] m_read(input logic [4:0] a, input logic [1:0] we,
                                         input logic [4:0] wn [2], input logic [31:0] d [2]);
    if (a == 0) return 32'h0;
    for (int w = 1; w >= 0; w--) if (we[w] && wn[w] == a) return d[w];
    return m_reg[a];
  endfunction

  function automatic logic m_rdy(input logic [4:0] a, input logic [1:0] we,
                                 input logic [1:0] wclr, input logic [4:0] wn [2]);
    if (a == 0) return 1'b1;
    if (!m_pend[a]) return 1'b1;
    for (int w = 0; w < 2; w++) if (we[w] && wclr[w] && wn[w] == a) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_pend_vec();
    logic [31:0] v;
    for (int i = 0; i < DEPTH; i++) v[i] = m_pend[i];
    return v;
  endfunction

  initial begin
    logic [4:0]  wn [2];
    logic [31:0] d  [2];
    logic [1:0]  we, wclr;
    logic        mark, r;
    logic [4:0]  mark_n, rn0, rn1;

    drive(1'b1, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 2'b00, 1'b0, 5'd0, 5'd0, 5'd0);

    // Reset for two cycles, then read every address.
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int a = 0; a < DEPTH; a++) begin
      @(negedge clk);
      bus.rn = {5'(31 - a), 5'(a)};
      #1;
      chk($sformatf("reset q0 a=%0d", a), bus.q[31:0], 32'h0);
      chk($sformatf("reset q1 a=%0d", a), bus.q[63:32], 32'h0);
      chk($sformatf("reset rdy a=%0d", a), {30'h0, bus.q_rdy}, 32'h3);
      chk($sformatf("reset pend a=%0d", a), bus.pend, 32'h0);
    end

    //       rst  we     wn0 wn1 d0            d1     wclr  mk mk_n rn0 rn1 eq0           eq1           rdy    pend
    add_vec(1'b0, 2'b01, 5,  0,  32'hDEADBEEF, 0,     2'b00, 0, 0,  5,  0,  32'hDEADBEEF, 0,            2'b11, 0);
    add_vec(1'b0, 2'b00, 0,  0,  0,            0,     2'b00, 0, 0,  5,  5,  32'hDEADBEEF, 32'hDEADBEEF, 2'b11, 0);
    add_vec(1'b0, 2'b11, 7,  7,  1,            2,     2'b00, 0, 0,  7,  5,  2,            32'hDEADBEEF, 2'b11, 0);
    add_vec(1'b0, 2'b00, 0,  0,  0,            0,     2'b00, 0, 0,  7,  7,  2,            2,            2'b11, 0);
    add_vec(1'b0, 2'b00, 0,  0,  0,            0,     2'b00, 1, 9,  9,  7,  0,            2,            2'b11, 0);
    add_vec(1'b0, 2'b00, 0,  0,  0,            0,     2'b00, 0, 0,  9,  9,  0,            0,            2'b00, 32'h200);
    add_vec(1'b0, 2'b10, 0,  9,  0,            32'h55, 2'b10, 0, 0, 9,  9,  32'h55,       32'h55,       2'b11, 32'h200);
    add_vec(1'b0, 2'b00, 0,  0,  0,            0,     2'b00, 0, 0,  9,  0,  32'h55,       0,            2'b11, 0);
    add_vec(1'b0, 2'b01, 3,  0,  32'h33,       0,     2'b01, 1, 3,  3,  9,  32'h33,       32'h55,       2'b11, 0);
    add_vec(1'b0, 2'b00, 0,  0,  0,            0,     2'b00, 0, 0,  3,  3,  32'h33,       32'h33,       2'b00, 32'h8);
    add_vec(1'b0, 2'b01, 3,  0,  32'h44,       0,     2'b00, 0, 0,  3,  0,  32'h44,       0,            2'b10, 32'h8);
    add_vec(1'b0, 2'b00, 0,  0,  0,            0,     2'b00, 0, 0,  3,  3,  32'h44,       32'h44,       2'b00, 32'h8);
    add_vec(1'b0, 2'b01, 0,  0,  32'hFF,       0,     2'b00, 1, 0,  0,  0,  0,            0,            2'b11, 32'h8);
    add_vec(1'b0, 2'b00, 0,  0,  0,            0,     2'b00, 0, 0,  0,  3,  0,            32'h44,       2'b01, 32'h8);
    add_vec(1'b1, 2'b01, 4,  0,  32'h77,       0,     2'b00, 0, 0,  4,  3,  32'h77,       32'h44,       2'b01, 32'h8);
    add_vec(1'b0, 2'b00, 0,  0,  0,            0,     2'b00, 0, 0,  4,  3,  0,            0,            2'b11, 0);

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].we, vecs[i].wn0, vecs[i].wn1, vecs[i].d0, vecs[i].d1,
            vecs[i].wclr, vecs[i].mark, vecs[i].mark_n, vecs[i].rn0, vecs[i].rn1);
      #1;
      chk($sformatf("vec%0d q0", i), bus.q[31:0], vecs[i].eq0);
      chk($sformatf("vec%0d q1", i), bus.q[63:32], vecs[i].eq1);
      chk($sformatf("vec%0d rdy", i), {30'h0, bus.q_rdy}, {30'h0, vecs[i].erdy});
      chk($sformatf("vec%0d pend", i), bus.pend, vecs[i].epend);
    end

    // Randomised traffic against the reference model; first cycle resets.
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      r      = (i == 0) || ($urandom_range(0, 49) == 0);
      we     = 2'($urandom);
      wclr   = 2'($urandom);
      mark   = ($urandom_range(0, 2) == 0);
      mark_n = 5'($urandom_range(0, 7));
      for (int w = 0; w < 2; w++) begin
        wn[w] = 5'($urandom_range(0, 7));
        d[w]  = $urandom;
      end
      rn0 = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      rn1 = 5'($urandom_range(0, 7));
      drive(r, we, wn[0], wn[1], d[0], d[1], wclr, mark, mark_n, rn0, rn1);
      #1;
      if (i > 0) begin
        chk($sformatf("rnd%0d q0", i), bus.q[31:0], m_read(rn0, we, wn, d));
        chk($sformatf("rnd%0d q1", i), bus.q[63:32], m_read(rn1, we, wn, d));
        chk($sformatf("rnd%0d rdy", i), {30'h0, bus.q_rdy},
            {30'h0, m_rdy(rn1, we, wclr, wn), m_rdy(rn0, we, wclr, wn)});
        chk($sformatf("rnd%0d pend", i), bus.pend, m_pend_vec());
      end
      @(posedge clk);
      if (r) begin
        for (int a = 0; a < DEPTH; a++) begin
          m_reg[a]  = 32'h0;
          m_pend[a] = 1'b0;
        end
      end else begin
        for (int w = 0; w < 2; w++) if (we[w] && wn[w] != 0) m_reg[wn[w]] = d[w];
        for (int w = 0; w < 2; w++) if (we[w] && wclr[w]) m_pend[wn[w]] = 1'b0;
        if (mark && mark_n != 0) m_pend[mark_n] = 1'b1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port successor to the single-write/dual-read CPU register file.
- Supports N read ports, M write ports, and write-to-read bypass on every read port.
- Has an optional hardwired-zero register 0.
- Adds a per-register pending-write scoreboard, so the pipeline can stall on producers that are still in flight, such as loads and multi-cycle multiply/divide.
- Sits between decode (reads, marks) and writeback (writes, clears).

Parameters:
- WIDTH, 32, data width in bits.
- DEPTH, 32, number of registers; power of two, at least 2.
- AW, $clog2(DEPTH), register address width (derived; do not override).
- NR, 2, number of read ports, at least 1.
- NW, 2, number of write ports, at least 1.
- ZERO_REG, 1, if 1, register 0 reads as 0, ignores writes, and is never pending.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous active-high reset.
- rn  in  NR*AW  read addresses; port r occupies bits [r*AW +: AW].
- q  out  NR*WIDTH  read data; port r occupies bits [r*WIDTH +: WIDTH].
- q_rdy  out  NR  port r: the data on q is valid (not pending, or bypassed this cycle).
- we  in  NW  write enables.
- wn  in  NW*AW  write addresses.
- d  in  NW*WIDTH  write data.
- wclr  in  NW  write port w also clears the pending bit of wn[w].
- mark  in  1  set the pending bit of mark_n.
- mark_n  in  AW  register to mark pending.
- pend  out  DEPTH  pending bit vector (registered state).

Behaviour:
- Reset:
  - Interface is synchronous active-high: clk rising edge with rst=1 clears all registers to 0 and all pend bits to 0.
  - Reset overrides every write, mark and clear in the same cycle.
  - Outputs are combinational from state. During and after reset, q shows 0 unless a bypass is active (bypass is combinational and ignores rst).
- Write:
  - At the rising edge, for each w with we[w]=1, register[wn[w]] <= d[w].
  - Write latency is 1 cycle to the array, 0 cycles via bypass.
- Write conflict: when several enabled ports target the same address, the highest-indexed port wins, for both data and bypass.
- Read:
  - Combinational. q[r] = d[w*] if some enabled w has wn[w]==rn[r], where w* is the highest such w; otherwise register[rn[r]].
- Zero register (ZERO_REG=1):
  - Address 0 always reads 0.
  - Address 0 is never bypassed and never written.
  - pend[0] is stuck at 0.
  - mark of address 0 is ignored.
  - q_rdy for address 0 is 1.
- Scoreboard update at the rising edge, in priority order (lowest first):
  1. pend[a] cleared if any w has we[w] & wclr[w] & wn[w]==a.
  2. pend[a] set if mark & mark_n==a; the mark beats a same-cycle clear, because it is a new producer.
- Bits not addressed hold their value.
- wclr with we=0 has no effect.
- q_rdy[r] = ~pend[rn[r]] | (some w: we[w] & wclr[w] & wn[w]==rn[r]).
  - A write without wclr does not make a pending register ready; this allows out-of-order partial writes.
- Reset mid-operation: all pending state is lost. The pipeline is flushed by the same reset, so no producer remains outstanding.
- No internal counters or stalls. The block never back-pressures; the consumer gates issue on q_rdy.

Decomposition:
- Shared package regfile_pkg holds:
  - a default width constant;
  - a default depth constant;
  - a function that computes the winning write port for an address (returns a valid flag and an index).
- One sub-module, regfile_bypass, holds one read port's combinational bypass and zero-register mux; it is instantiated NR times from a generate loop.
- The storage and scoreboard stay in regfile_mp.

Test Plan:
1. Reset and readback: hold rst for 2 cycles, then read every address on all ports -> q=0, q_rdy=1, pend=0.
2. Write then read: we[0]=1, wn=5, d=32'hDEADBEEF; read rn[0]=5 in the same cycle -> q=DEADBEEF (bypass). In the next cycle with we=0 -> q=DEADBEEF from the array.
3. Write conflict: we=2'b11, wn[0]=wn[1]=7, d[0]=1, d[1]=2 -> same-cycle read of address 7 gives 2; next cycle it gives 2.
4. Scoreboard:
   - mark with mark_n=9 -> next cycle pend[9]=1 and q_rdy=0 for rn=9.
   - we[1]=1, wclr[1]=1, wn[1]=9, d=0x55 -> same cycle q_rdy=1 and q=0x55; next cycle pend[9]=0.
5. Mark beats clear: in one cycle, mark_n=3 and a wclr write to address 3 -> next cycle pend[3]=1, register[3]=written data.
6. Zero register and reset priority:
   - Write 0xFF to address 0 -> reads 0; mark of address 0 -> pend[0]=0.
   - rst=1 concurrent with a write to address 4 -> register[4]=0 after the edge.
